mem_resp_ctrl: RTL and testbench
================================

Name: mem_resp_ctrl

Overview:
- Memory-side responder for the data-processor memory request interface.
- Accepts burst read requests from the input data processor (IDP) and single read/write requests from a second client (OTH).
- Arbitrates between the two clients and drives a synchronous single-port SRAM.
- Returns read data on MEM_DIN/MEM_VLD and terminates every transaction with a MEM_FIN pulse.
- Sits between the IDP/ODP layer and the feature-map SRAM.

Parameters:
- AW, 18, SRAM word-address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MEM_REQ  in  1  IDP request; held high until MEM_FIN is seen.
- MEM_ADDR  in  32  IDP byte start address; word address = MEM_ADDR[AW+1:2].
- MEM_CMD  in  4  IDP burst length minus 1 (1–16 beats).
- MEM_DIN  out  DW  read data to IDP.
- MEM_VLD  out  1  MEM_DIN valid for IDP, one beat per cycle.
- MEM_FIN  out  1  one-cycle end-of-transaction pulse to IDP.
- MEM_IDP_SEL  out  1  high while the granted transaction belongs to IDP.
- OTH_REQ  in  1  OTH request; held until OTH_FIN.
- OTH_WE  in  1  1 = write, 0 = read (single beat).
- OTH_ADDR  in  32  OTH byte address.
- OTH_WDATA  in  DW  OTH write data.
- OTH_RDATA  out  DW  OTH read data.
- OTH_VLD  out  1  OTH_RDATA valid.
- OTH_FIN  out  1  one-cycle end-of-transaction pulse to OTH.
- SRAM_CS  out  1  SRAM access enable.
- SRAM_WE  out  1  SRAM write enable.
- SRAM_ADDR  out  AW  SRAM word address.
- SRAM_WDATA  out  DW  SRAM write data.
- SRAM_RDATA  in  DW  SRAM read data, valid 1 cycle after SRAM_CS with SRAM_WE=0.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = IDP.
- States:
  - IDLE → GRANT when any REQ is high.
  - GRANT: latch client, address, burst length (OTH: always 1), WE and WDATA; set MEM_IDP_SEL if IDP is granted. → ISSUE.
  - ISSUE: SRAM_CS=1 for exactly N consecutive cycles. SRAM_ADDR starts at the latched word address and increments by 1 per cycle, wrapping modulo 2^AW. OTH write: SRAM_WE=1 for 1 cycle, no VLD.
  - DRAIN: one cycle for the final read beat. Writes skip DRAIN.
  - FIN: the granted client's FIN=1 for exactly one cycle. → IDLE.
- Read data path: VLD and DIN/RDATA are registered from SRAM_RDATA one cycle after each SRAM_CS beat, giving N back-to-back VLD beats. The first VLD appears 3 cycles after the REQ rising edge, measured from IDLE.
- FIN timing: read FIN is asserted in the cycle after the last VLD. Write FIN is asserted in the cycle after the SRAM_WE cycle.
- MEM_IDP_SEL stays high from GRANT through FIN inclusive and falls when the state returns to IDLE.
- Requests held from the FIN cycle are ignored. The client must deassert REQ on the cycle after FIN; a REQ still high in IDLE is treated as a new request.
- A REQ falling mid-transaction does not abort it; the burst completes.
- Arbitration with both REQs high in IDLE: fixed priority to IDP unless the optional feature is compiled in.
- Reset asserted mid-burst: immediate abort, outputs return to 0, no FIN is issued.
- MEM_CMD=4'hF gives 16 beats. MEM_CMD=0 gives 1 beat.

Optional Feature:
- Macro MEMC_RR_ARB_EN.
- Defined: round-robin arbitration. After each FIN the pointer moves to the other client, so with both REQs continuously high, grants alternate IDP, OTH, IDP, …
- Undefined: IDP has strict priority; the pointer register is not instantiated.

Decomposition:
- Package mem_resp_pkg holds:
  - state enum (IDLE, GRANT, ISSUE, DRAIN, FIN);
  - client-ID constants CL_IDP=0 and CL_OTH=1;
  - function byte-to-word address.
- One natural sub-module, mem_resp_arb: the 2-client arbiter holding the fixed-priority/round-robin logic and the pointer. The FSM and datapath stay in the top.

Test Plan:
- IDP burst: MEM_ADDR=0x0000_0010, MEM_CMD=5; SRAM preloaded word[4+k]=0xA000_0000+k.
  - Expect 6 VLD beats 0xA000_0000..0xA000_0005, back to back.
  - Expect FIN one cycle after the last beat.
  - Expect MEM_IDP_SEL high for the whole transaction.
- OTH write then read:
  - Write 0xDEAD_BEEF to 0x40 → SRAM_WE pulse at word 0x10, then OTH_FIN.
  - Read 0x40 → OTH_VLD with 0xDEAD_BEEF, then OTH_FIN.
  - MEM_IDP_SEL stays 0 throughout.
- Simultaneous REQs for 4 transactions:
  - Without MEMC_RR_ARB_EN: expected grant order IDP, IDP, IDP, IDP.
  - With MEMC_RR_ARB_EN: expected grant order IDP, OTH, IDP, OTH.
- Wrap-around: MEM_ADDR word 2^AW−2, MEM_CMD=3 → SRAM_ADDR sequence 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- Reset mid-burst: rst_n low during beat 3 of a 16-beat read.
  - All outputs go to 0 asynchronously, with no FIN.
  - After release, a new 1-beat request completes normally.
- MEM_CMD=0: exactly one VLD beat, FIN on the next cycle, and the state returns to IDLE.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// -----------------------------------------------------------------------------
// mem_resp_pkg
// Shared types and helpers for the memory-side responder (mem_resp_ctrl).
//   state_t      : transaction FSM states
//   CL_IDP/CL_OTH: client identifiers used by the arbiter and the FSM
//   byte_to_word : byte address -> 32-bit word address (drop the 2 LSBs)
// -----------------------------------------------------------------------------
package mem_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ISSUE,
    DRAIN,
    FIN
  } state_t;

  localparam logic CL_IDP = 1'b0;
  localparam logic CL_OTH = 1'b1;

  // Callers keep the low AW bits of the result.
  function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/mem_resp_arb.sv
// -----------------------------------------------------------------------------
// mem_resp_arb
// Two-client arbiter for mem_resp_ctrl. Purely combinational grant; the FSM
// samples it only in IDLE.
//   Build option MEMC_RR_ARB_EN:
//     defined   - round-robin: when both request, the pointer's client wins;
//                 after every completed transaction the pointer moves to the
//                 client that was not just served.
//     undefined - IDP has strict priority; no pointer register exists.
// Ports:
//   clk, rst_n : clock / async active-low reset (pointer register only)
//   req_idp    : IDP request
//   req_oth    : OTH request
//   done       : one-cycle pulse, transaction finished (FIN state)
//   served     : client that owned the finishing transaction
//   gnt        : winning client (CL_IDP / CL_OTH); CL_IDP when nobody asks
// -----------------------------------------------------------------------------
module mem_resp_arb
  import mem_resp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_idp,
  input  logic req_oth,
  input  logic done,
  input  logic served,
  output logic gnt
);

`ifdef MEMC_RR_ARB_EN
  logic ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= CL_IDP;
    end else if (done) begin
      ptr_q <= ~served;
    end
  end

  always_comb begin
    gnt = CL_IDP;
    if (req_idp && req_oth) begin
      gnt = ptr_q;
    end else if (req_oth) begin
      gnt = CL_OTH;
    end
  end
`else
  // Fixed priority needs no state; keep the shared port list tidy for lint.
  logic unused_rr_inputs;
  assign unused_rr_inputs = &{1'b0, clk, rst_n, done, served};

  always_comb begin
    gnt = CL_IDP;
    if (!req_idp && req_oth) begin
      gnt = CL_OTH;
    end
  end
`endif

endmodule

// File: rtl/mem_resp_ctrl.sv
// -----------------------------------------------------------------------------
// mem_resp_ctrl
// Memory-side responder between the IDP/OTH clients and a synchronous
// single-port SRAM. IDP issues burst reads (1..16 beats), OTH issues single
// reads or writes. Every transaction ends with a one-cycle FIN to its owner.
// Build option: MEMC_RR_ARB_EN selects round-robin arbitration (see
// mem_resp_arb); default is IDP strict priority.
//
// Parameters: AW (SRAM word-address width), DW (data width)
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   MEM_REQ/ADDR/CMD           IDP request, byte address, beats-1
//   MEM_DIN/VLD/FIN            IDP read data, data valid, end pulse
//   MEM_IDP_SEL                high while IDP owns the transaction
//   OTH_REQ/WE/ADDR/WDATA      OTH request, write flag, byte address, data
//   OTH_RDATA/VLD/FIN          OTH read data, data valid, end pulse
//   SRAM_CS/WE/ADDR/WDATA      SRAM strobe, write enable, word address, data
//   SRAM_RDATA                 SRAM read data (1 cycle after a read strobe)
//
// Timeline (REQ seen in IDLE at cycle 0):
//   1: GRANT  2..N+1: ISSUE (one SRAM beat each)  N+2: DRAIN  N+3: FIN
//   Read data appears in cycles 3..N+2, so FIN follows the last beat.
//   Writes go ISSUE -> FIN directly.
// -----------------------------------------------------------------------------
module mem_resp_ctrl
  import mem_resp_pkg::*;
#(
  parameter int AW = 18,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          MEM_REQ,
  input  logic [31:0]   MEM_ADDR,
  input  logic [3:0]    MEM_CMD,
  output logic [DW-1:0] MEM_DIN,
  output logic          MEM_VLD,
  output logic          MEM_FIN,
  output logic          MEM_IDP_SEL,
  input  logic          OTH_REQ,
  input  logic          OTH_WE,
  input  logic [31:0]   OTH_ADDR,
  input  logic [DW-1:0] OTH_WDATA,
  output logic [DW-1:0] OTH_RDATA,
  output logic          OTH_VLD,
  output logic          OTH_FIN,
  output logic          SRAM_CS,
  output logic          SRAM_WE,
  output logic [AW-1:0] SRAM_ADDR,
  output logic [DW-1:0] SRAM_WDATA,
  input  logic [DW-1:0] SRAM_RDATA
);

  state_t        state_q, next_state;
  logic          client_q;   // owner of the current transaction
  logic [AW-1:0] addr_q;     // next SRAM word address to issue
  logic [3:0]    len_q;      // beats - 1
  logic [3:0]    cnt_q;      // beats issued so far in ISSUE
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic          rd_vld_q;   // SRAM_RDATA carries a beat this cycle
  logic          gnt;
  logic          any_req;

  assign any_req = MEM_REQ || OTH_REQ;

  mem_resp_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_idp (MEM_REQ),
    .req_oth (OTH_REQ),
    .done    (state_q == FIN),
    .served  (client_q),
    .gnt     (gnt)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // NOTE: next_state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE:    if (any_req) next_state = GRANT;
      GRANT:   next_state = ISSUE;
      ISSUE:   if (cnt_q == len_q) next_state = we_q ? FIN : DRAIN;
      DRAIN:   next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // NOTE: these are plain control/address registers, not a storage array, so
  // they are all reset; that keeps every output at zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      client_q <= CL_IDP;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= (state_q == ISSUE) && !we_q;
      case (state_q)
        IDLE: begin
          // Owner is fixed on entry to GRANT so MEM_IDP_SEL covers GRANT too.
          if (any_req) client_q <= gnt;
        end
        GRANT: begin
          cnt_q <= '0;
          if (client_q == CL_IDP) begin
            addr_q  <= AW'(byte_to_word(MEM_ADDR));
            len_q   <= MEM_CMD;
            we_q    <= 1'b0;
            wdata_q <= '0;
          end else begin
            addr_q  <= AW'(byte_to_word(OTH_ADDR));
            len_q   <= '0;
            we_q    <= OTH_WE;
            wdata_q <= OTH_WDATA;
          end
        end
        ISSUE: begin
          // Natural AW-bit overflow gives the modulo-2^AW wrap.
          addr_q <= addr_q + AW'(1);
          cnt_q  <= cnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic is_idp;
  assign is_idp = (client_q == CL_IDP);

  assign SRAM_CS    = (state_q == ISSUE);
  assign SRAM_WE    = SRAM_CS && we_q;
  assign SRAM_ADDR  = SRAM_CS ? addr_q : '0;
  assign SRAM_WDATA = SRAM_WE ? wdata_q : '0;

  // The valid flag is registered from the strobe; the data itself comes from
  // the SRAM output register, which already holds it for exactly that cycle.
  // A second data register here would push the last beat past DRAIN.
  assign MEM_VLD   = rd_vld_q && is_idp;
  assign OTH_VLD   = rd_vld_q && !is_idp;
  assign MEM_DIN   = MEM_VLD ? SRAM_RDATA : '0;
  assign OTH_RDATA = OTH_VLD ? SRAM_RDATA : '0;

  assign MEM_FIN     = (state_q == FIN) && is_idp;
  assign OTH_FIN     = (state_q == FIN) && !is_idp;
  assign MEM_IDP_SEL = (state_q != IDLE) && is_idp;

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_resp_ctrl
// Self-checking bench for mem_resp_ctrl: SRAM behavioural model, output
// monitor, and a reference memory predicting read data, SRAM access order,
// beat timing and FIN placement. Honours MEMC_RR_ARB_EN for grant order.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_resp_ctrl;
  import mem_resp_pkg::*;

  localparam int AW    = 18;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          MEM_REQ = 1'b0;
  logic [31:0]   MEM_ADDR = '0;
  logic [3:0]    MEM_CMD = '0;
  logic [DW-1:0] MEM_DIN;
  logic          MEM_VLD, MEM_FIN, MEM_IDP_SEL;
  logic          OTH_REQ = 1'b0;
  logic          OTH_WE = 1'b0;
  logic [31:0]   OTH_ADDR = '0;
  logic [DW-1:0] OTH_WDATA = '0;
  logic [DW-1:0] OTH_RDATA;
  logic          OTH_VLD, OTH_FIN;
  logic          SRAM_CS, SRAM_WE;
  logic [AW-1:0] SRAM_ADDR;
  logic [DW-1:0] SRAM_WDATA;
  logic [DW-1:0] SRAM_RDATA = '0;

  mem_resp_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_CMD(MEM_CMD),
    .MEM_DIN(MEM_DIN), .MEM_VLD(MEM_VLD), .MEM_FIN(MEM_FIN),
    .MEM_IDP_SEL(MEM_IDP_SEL),
    .OTH_REQ(OTH_REQ), .OTH_WE(OTH_WE), .OTH_ADDR(OTH_ADDR),
    .OTH_WDATA(OTH_WDATA), .OTH_RDATA(OTH_RDATA), .OTH_VLD(OTH_VLD),
    .OTH_FIN(OTH_FIN),
    .SRAM_CS(SRAM_CS), .SRAM_WE(SRAM_WE), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WDATA(SRAM_WDATA), .SRAM_RDATA(SRAM_RDATA)
  );

  always #5 clk = ~clk;

  // ---------------- SRAM model ----------------
  logic [DW-1:0] sram [DEPTH];

  function automatic logic [DW-1:0] init_pat(input int a);
    return DW'(a) * 32'h9E37_79B9 + 32'h1234_5678;
  endfunction

  always @(posedge clk) begin
    if (SRAM_CS) begin
      if (SRAM_WE) sram[SRAM_ADDR] = SRAM_WDATA;
      else         SRAM_RDATA <= sram[SRAM_ADDR];
    end
  end

  // ---------------- reference memory ----------------
  logic [DW-1:0] ref_mem [int];

  function automatic logic [DW-1:0] ref_rd(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_pat(a);
  endfunction

  // ---------------- monitor ----------------
  int            cyc = 0;
  logic [DW-1:0] idp_data[$], oth_data[$], acc_wd[$];
  int            idp_vcyc[$], oth_vcyc[$], acc_addr[$], fin_order[$];
  bit            acc_we[$];
  int            fin_cyc = 0;
  int            sel_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (MEM_VLD) begin idp_data.push_back(MEM_DIN); idp_vcyc.push_back(cyc); end
    if (OTH_VLD) begin oth_data.push_back(OTH_RDATA); oth_vcyc.push_back(cyc); end
    if (SRAM_CS) begin
      acc_addr.push_back(int'(SRAM_ADDR));
      acc_we.push_back(SRAM_WE);
      acc_wd.push_back(SRAM_WDATA);
    end
    if (MEM_FIN) begin fin_order.push_back(0); fin_cyc = cyc; end
    if (OTH_FIN) begin fin_order.push_back(1); fin_cyc = cyc; end
    if (MEM_IDP_SEL) sel_cnt++;
  end

  task automatic clear_mon();
    idp_data.delete(); oth_data.delete(); acc_wd.delete();
    idp_vcyc.delete(); oth_vcyc.delete(); acc_addr.delete();
    fin_order.delete(); acc_we.delete();
    sel_cnt = 0;
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({MEM_DIN, MEM_VLD, MEM_FIN, MEM_IDP_SEL, OTH_RDATA, OTH_VLD,
                 OTH_FIN, SRAM_CS, SRAM_WE, SRAM_ADDR, SRAM_WDATA});
  endfunction

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction from a single client, then verify everything the
  // reference predicts for it. Timing is relative to c0, the cycle in which
  // REQ is first presented to an idle controller.
  task automatic run_txn(input bit cl, input bit we, input logic [31:0] addr,
                         input logic [3:0] cmd, input logic [DW-1:0] wd);
    int c0, n, a;
    bit got;
    clear_mon();
    @(posedge clk); #1;
    c0 = cyc;
    if (cl == CL_IDP) begin
      MEM_ADDR = addr; MEM_CMD = cmd; MEM_REQ = 1'b1;
    end else begin
      OTH_ADDR = addr; OTH_WE = we; OTH_WDATA = wd; OTH_REQ = 1'b1;
    end
    n = (cl == CL_IDP) ? int'(cmd) + 1 : 1;
    a = int'(addr >> 2) % DEPTH;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk); #1;
      got = (fin_order.size() > 0);
    end
    check("fin_seen", 128'(got), 128'(1));
    @(posedge clk); #1;
    MEM_REQ = 1'b0; OTH_REQ = 1'b0;
    @(negedge clk); #1;
    check("back_to_idle", 128'(dut.state_q), 128'(IDLE));
    check("fin_count", 128'(fin_order.size()), 128'(1));
    if (fin_order.size() > 0) check("fin_owner", 128'(fin_order[0]), 128'(cl));
    check("idp_sel_cycles", 128'(sel_cnt), 128'((cl == CL_IDP) ? n + 3 : 0));
    check("sram_beats", 128'(acc_addr.size()), 128'(n));
    if (we) begin
      check("wr_fin_cyc", 128'(fin_cyc), 128'(c0 + 3));
      check("wr_no_vld", 128'(idp_data.size() + oth_data.size()), 128'(0));
      if (acc_addr.size() > 0) begin
        check("wr_addr", 128'(acc_addr[0]), 128'(a));
        check("wr_we", 128'(acc_we[0]), 128'(1));
        check("wr_data", 128'(acc_wd[0]), 128'(wd));
      end
      ref_mem[a] = wd;
    end else begin
      check("rd_fin_cyc", 128'(fin_cyc), 128'(c0 + 3 + n));
      check("rd_beats", 128'(cl ? oth_data.size() : idp_data.size()), 128'(n));
      check("rd_wrong_client",
            128'(cl ? idp_data.size() : oth_data.size()), 128'(0));
      for (int k = 0; k < n; k++) begin
        int wa = (a + k) % DEPTH;
        if (k < acc_addr.size()) begin
          check($sformatf("rd_addr[%0d]", k), 128'(acc_addr[k]), 128'(wa));
          check($sformatf("rd_we[%0d]", k), 128'(acc_we[k]), 128'(0));
        end
        if (cl == CL_IDP && k < idp_data.size()) begin
          check($sformatf("idp_data[%0d]", k), 128'(idp_data[k]), 128'(ref_rd(wa)));
          check($sformatf("idp_vcyc[%0d]", k), 128'(idp_vcyc[k]), 128'(c0 + 3 + k));
        end
        if (cl == CL_OTH && k < oth_data.size()) begin
          check("oth_data", 128'(oth_data[k]), 128'(ref_rd(wa)));
          check("oth_vcyc", 128'(oth_vcyc[k]), 128'(c0 + 3));
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_order[4];
    bit got;

    for (int i = 0; i < DEPTH; i++) sram[i] = init_pat(i);
    for (int k = 0; k < 6; k++) begin
      sram[4 + k]    = 32'hA000_0000 + k;
      ref_mem[4 + k] = 32'hA000_0000 + k;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 128'(0));
    check("reset_state", 128'(dut.state_q), 128'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // IDP burst: byte 0x10 -> word 4, 6 beats of 0xA000_000k
    run_txn(CL_IDP, 1'b0, 32'h0000_0010, 4'd5, '0);

    // OTH write then read of byte 0x40 (word 0x10)
    run_txn(CL_OTH, 1'b1, 32'h0000_0040, 4'd0, 32'hDEAD_BEEF);
    check("sram_written", 128'(sram[16'h10]), 128'(32'hDEAD_BEEF));
    run_txn(CL_OTH, 1'b0, 32'h0000_0040, 4'd0, '0);

    // Both clients requesting continuously for four transactions
`ifdef MEMC_RR_ARB_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    clear_mon();
    @(posedge clk); #1;
    MEM_ADDR = 32'h0000_0200; MEM_CMD = 4'd2; MEM_REQ = 1'b1;
    OTH_ADDR = 32'h0000_0300; OTH_WE = 1'b0; OTH_REQ = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk); #1;
      got = (fin_order.size() >= 4);
    end
    check("arb_fin_seen", 128'(got), 128'(1));
    @(posedge clk); #1;
    MEM_REQ = 1'b0; OTH_REQ = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("arb_fin_total", 128'(fin_order.size()), 128'(4));
    for (int i = 0; i < 4 && i < fin_order.size(); i++)
      check($sformatf("arb_order[%0d]", i), 128'(fin_order[i]), 128'(exp_order[i]));
    check("arb_idle", 128'(dut.state_q), 128'(IDLE));

    // Address wrap: word 2^AW-2, 4 beats
    run_txn(CL_IDP, 1'b0, 32'((DEPTH - 2) * 4), 4'd3, '0);

    // Reset during beat 3 of a 16-beat read
    clear_mon();
    @(posedge clk); #1;
    MEM_ADDR = 32'h0000_1000; MEM_CMD = 4'hF; MEM_REQ = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); #1;
      got = (acc_addr.size() >= 3);
    end
    check("burst_reached_beat3", 128'(got), 128'(1));
    rst_n = 1'b0;
    #1;
    check("abort_outputs", all_outs(), 128'(0));
    MEM_REQ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_fin", 128'(fin_order.size()), 128'(0));
    check("abort_state", 128'(dut.state_q), 128'(IDLE));
    check("abort_outputs_held", all_outs(), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // MEM_CMD = 0: single beat after the aborted burst
    run_txn(CL_IDP, 1'b0, 32'h0000_0014, 4'd0, '0);

    // Randomized single-client traffic over a small overlapping window
    for (int t = 0; t < 24; t++) begin
      bit          cl = 1'($urandom_range(0, 1));
      bit          we = cl ? 1'($urandom_range(0, 1)) : 1'b0;
      logic [31:0] ad = 32'h0000_0100 + (32'($urandom_range(0, 31)) << 2);
      logic [3:0]  cm = 4'($urandom_range(0, 15));
      logic [31:0] wd = $urandom;
      run_txn(cl, we, ad, cm, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
